lane_encoder4: RTL and testbench

LANE_ENCODER4 -- requirements
Module: lane_encoder4

---
 rtl/lane_encoder4.sv | 183 ++++++++++++++++++
 tb/tb_lane_encoder4.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lane_encoder4.sv
// lane_encoder4: four asynchronous, active-high lane pads are synchronized,
// optionally debounced and edge-detected. Each rising lane edge is
// priority-encoded (highest index wins) into a one-deep event register
// with a valid/ready handshake.
//
// Build option: define LANE_ENCODER4_DEBOUNCE_EN to include the per-lane
// debounce counters. Without it the debounced vector simply follows the
// synchronizer output and DEBOUNCE_CYCLES is ignored.
module lane_encoder4 #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] I,
  output logic [1:0] O_code,
  output logic       O_valid,
  input  logic       O_ready,
  output logic       O_multi,
  output logic       O_overrun
);

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  // The counter compare value; a lane toggles on the sample that would make
  // the run of differing samples reach DEBOUNCE_CYCLES.
  localparam logic [15:0] DEB_LAST = 16'(DEBOUNCE_CYCLES - 1);

  logic [3:0] sync1_q;
  logic [3:0] sync2_q;
  logic [3:0] db_q;
  logic [3:0] db_d;
  logic [3:0] press;

  state_t     state_q;
  state_t     state_d;
  logic [1:0] code_q;
  logic [1:0] code_d;
  logic       multi_q;
  logic       multi_d;
  logic       ovr_q;
  logic       ovr_d;

  // Highest set bit wins.
  function automatic logic [1:0] enc_hi(input logic [3:0] v);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (v[i]) r = 2'(i);
    end
    return r;
  endfunction

  // True when two or more bits are set.
  function automatic logic is_multi(input logic [3:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 4; i++) begin
      n = n + {2'b00, v[i]};
    end
    return (n > 3'd1);
  endfunction

  // Two-flop synchronizer for the asynchronous pads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 4'b0000;
      sync2_q <= 4'b0000;
    end else begin
      sync1_q <= I;
      sync2_q <= sync1_q;
    end
  end

`ifdef LANE_ENCODER4_DEBOUNCE_EN
  logic [3:0][15:0] cnt_q;
  logic [3:0][15:0] cnt_d;

  // Per-lane debounce: count consecutive samples that disagree with the
  // debounced value and flip the lane once the run is long enough.
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    for (int k = 0; k < 4; k++) begin
      if (sync2_q[k] != db_q[k]) begin
        if (cnt_q[k] == DEB_LAST) begin
          db_d[k]  = ~db_q[k];
          cnt_d[k] = 16'd0;
        end else begin
          cnt_d[k] = cnt_q[k] + 16'd1;
        end
      end
    end
  end

  // Debounce counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_deb_last;
  assign unused_deb_last = ^DEB_LAST;

  // No debounce: the lane vector follows the synchronizer directly.
  always_comb begin
    db_d = sync2_q;
  end
`endif

  // Debounced lane vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_q <= 4'b0000;
    end else begin
      db_q <= db_d;
    end
  end

  // Only 0->1 lane transitions are events; releases are ignored.
  always_comb begin
    press = db_d & ~db_q;
  end

  // Handshake FSM: load on a press when idle or when the pending event is
  // being accepted in the same cycle; otherwise a new press is dropped.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    multi_d = multi_q;
    ovr_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (press != 4'b0000) begin
          code_d  = enc_hi(press);
          multi_d = is_multi(press);
          state_d = PEND;
        end
      end
      PEND: begin
        if (O_ready) begin
          if (press != 4'b0000) begin
            code_d  = enc_hi(press);
            multi_d = is_multi(press);
          end else begin
            state_d = IDLE;
          end
        end else if (press != 4'b0000) begin
          ovr_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Event register, state and overrun pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      code_q  <= 2'b00;
      multi_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      multi_q <= multi_d;
      ovr_q   <= ovr_d;
    end
  end

  assign O_valid   = (state_q == PEND);
  assign O_code    = code_q;
  assign O_multi   = multi_q;
  assign O_overrun = ovr_q;

endmodule

// File: tb/tb_lane_encoder4.sv
// Testbench for lane_encoder4 (DEBOUNCE_CYCLES=4). Works with and without
// LANE_ENCODER4_DEBOUNCE_EN; expected latency follows the build.
module tb_lane_encoder4;

  localparam int DEB = 4;
`ifdef LANE_ENCODER4_DEBOUNCE_EN
  localparam int LAT = 2 + DEB;
  localparam int GLITCH_EVENTS = 0;
`else
  localparam int LAT = 3;
  localparam int GLITCH_EVENTS = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] I = 4'b0000;
  logic       O_ready = 1'b0;
  logic [1:0] O_code;
  logic       O_valid;
  logic       O_multi;
  logic       O_overrun;

  int nerr = 0;
  int nchk = 0;

  lane_encoder4 #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .I        (I),
    .O_code   (O_code),
    .O_valid  (O_valid),
    .O_ready  (O_ready),
    .O_multi  (O_multi),
    .O_overrun(O_overrun)
  );

  always #5 clk = ~clk;

  // Reference model: a two-sample delay line, a run length per lane of
  // samples disagreeing with the stable value, and a one-slot event holder.
  logic [3:0] m_s1 = 4'b0, m_s2 = 4'b0, m_db = 4'b0, m_ndb, m_pr;
  int         m_run [4] = '{0, 0, 0, 0};
  logic       m_pend = 1'b0, m_multi = 1'b0, m_ovr = 1'b0;
  logic [1:0] m_code = 2'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1 = 4'b0; m_s2 = 4'b0; m_db = 4'b0;
      for (int k = 0; k < 4; k++) m_run[k] = 0;
      m_pend = 1'b0; m_multi = 1'b0; m_ovr = 1'b0; m_code = 2'b0;
    end else begin
      m_ndb = m_db;
      for (int k = 0; k < 4; k++) begin
        if (m_s2[k] != m_db[k]) begin
`ifdef LANE_ENCODER4_DEBOUNCE_EN
          m_run[k] = m_run[k] + 1;
          if (m_run[k] >= DEB) begin
            m_ndb[k] = m_s2[k];
            m_run[k] = 0;
          end
`else
          m_ndb[k] = m_s2[k];
`endif
        end else begin
          m_run[k] = 0;
        end
      end
      m_pr  = m_ndb & ~m_db;
      m_ovr = 1'b0;
      if (m_pr != 4'b0) begin
        if (!m_pend || O_ready) begin
          for (int k = 0; k < 4; k++) if (m_pr[k]) m_code = 2'(k);
          m_multi = ($countones(m_pr) > 1);
          m_pend  = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (m_pend && O_ready) begin
        m_pend = 1'b0;
      end
      m_s2 = m_s1;
      m_s1 = I;
      m_db = m_ndb;
    end
  end

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; I = 4'b0; O_ready = 1'b0;
    #1;
    nchk++;
    if ({O_code, O_valid, O_multi, O_overrun} !== 5'b0) begin
      nerr++;
      $display("FAIL reset_hold: got code=%0d valid=%b multi=%b ovr=%b want all 0", O_code, O_valid, O_multi, O_overrun);
    end
    repeat (3) tick();
    rst_n = 1'b1;
    for (int n = 0; n < 10; n++) begin
      tick();
      nchk++;
      if ({O_code, O_valid, O_multi, O_overrun} !== 5'b0) begin
        nerr++;
        $display("FAIL reset_idle[%0d]: got code=%0d valid=%b multi=%b ovr=%b want all 0", n, O_code, O_valid, O_multi, O_overrun);
      end
    end
  endtask

  task automatic test_single_press();
    int vcount;
    vcount = 0;
    O_ready = 1'b1;
    I = 4'b0010;
    for (int n = 1; n <= LAT + 4; n++) begin
      tick();
      if (O_valid === 1'b1) vcount++;
      nchk++;
      if (O_valid !== (n == LAT)) begin
        nerr++;
        $display("FAIL single_valid_edge%0d: got valid=%b want %b", n, O_valid, (n == LAT));
      end
      if (n == LAT) begin
        nchk++;
        if (O_code !== 2'd1 || O_multi !== 1'b0) begin
          nerr++;
          $display("FAIL single_code: got code=%0d multi=%b want code=1 multi=0", O_code, O_multi);
        end
      end
    end
    nchk++;
    if (vcount != 1) begin
      nerr++;
      $display("FAIL single_pulse_len: got %0d valid cycles want 1", vcount);
    end
    I = 4'b0000;
    vcount = 0;
    for (int n = 0; n < 15; n++) begin
      tick();
      if (O_valid === 1'b1) vcount++;
    end
    nchk++;
    if (vcount != 0) begin
      nerr++;
      $display("FAIL release_no_event: got %0d valid cycles want 0", vcount);
    end
  endtask

  task automatic test_glitch();
    int vcount;
    vcount = 0;
    O_ready = 1'b1;
    I = 4'b0100;
    repeat (3) begin
      tick();
      if (O_valid === 1'b1) vcount++;
    end
    I = 4'b0000;
    for (int n = 0; n < 15; n++) begin
      tick();
      if (O_valid === 1'b1) vcount++;
      nchk++;
      if ({O_code, O_valid, O_multi, O_overrun} !== {m_code, m_pend, m_multi, m_ovr}) begin
        nerr++;
        $display("FAIL glitch_model[%0d]: got %b want %b", n, {O_code, O_valid, O_multi, O_overrun}, {m_code, m_pend, m_multi, m_ovr});
      end
    end
    nchk++;
    if (vcount != GLITCH_EVENTS) begin
      nerr++;
      $display("FAIL glitch_events: got %0d valid cycles want %0d", vcount, GLITCH_EVENTS);
    end
  endtask

  task automatic test_multi_overrun();
    int waited, ovr_count;
    bit bad_hold;
    O_ready = 1'b0;
    I = 4'b1001;
    waited = 0;
    while (O_valid !== 1'b1 && waited < 40) begin
      tick();
      waited++;
    end
    nchk++;
    if (O_valid !== 1'b1 || waited != LAT) begin
      nerr++;
      $display("FAIL multi_latency: got valid=%b after %0d edges want valid=1 after %0d", O_valid, waited, LAT);
    end
    nchk++;
    if (O_code !== 2'd3 || O_multi !== 1'b1) begin
      nerr++;
      $display("FAIL multi_code: got code=%0d multi=%b want code=3 multi=1", O_code, O_multi);
    end
    bad_hold = 1'b0;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (O_valid !== 1'b1 || O_code !== 2'd3 || O_multi !== 1'b1 || O_overrun !== 1'b0) bad_hold = 1'b1;
    end
    nchk++;
    if (bad_hold) begin
      nerr++;
      $display("FAIL multi_hold: got code=%0d valid=%b multi=%b at end want stable 3/1/1", O_code, O_valid, O_multi);
    end
    I = 4'b1011;
    ovr_count = 0;
    for (int n = 0; n < LAT + 8; n++) begin
      tick();
      if (O_overrun === 1'b1) ovr_count++;
      nchk++;
      if ({O_code, O_valid, O_multi, O_overrun} !== {m_code, m_pend, m_multi, m_ovr}) begin
        nerr++;
        $display("FAIL overrun_model[%0d]: got %b want %b", n, {O_code, O_valid, O_multi, O_overrun}, {m_code, m_pend, m_multi, m_ovr});
      end
    end
    nchk++;
    if (ovr_count != 1 || O_code !== 2'd3 || O_valid !== 1'b1) begin
      nerr++;
      $display("FAIL overrun_once: got pulses=%0d code=%0d valid=%b want pulses=1 code=3 valid=1", ovr_count, O_code, O_valid);
    end
    O_ready = 1'b1;
    I = 4'b0000;
    repeat (15) tick();
  endtask

  task automatic test_back_to_back();
    int waited;
    O_ready = 1'b0;
    I = 4'b0001;
    waited = 0;
    while (O_valid !== 1'b1 && waited < 40) begin
      tick();
      waited++;
    end
    nchk++;
    if (O_valid !== 1'b1 || O_code !== 2'd0) begin
      nerr++;
      $display("FAIL b2b_first: got valid=%b code=%0d want valid=1 code=0", O_valid, O_code);
    end
    I = 4'b0101;
    for (int n = 1; n <= LAT; n++) begin
      if (n == LAT) O_ready = 1'b1;
      tick();
      nchk++;
      if ({O_code, O_valid, O_multi, O_overrun} !== {m_code, m_pend, m_multi, m_ovr}) begin
        nerr++;
        $display("FAIL b2b_model[%0d]: got %b want %b", n, {O_code, O_valid, O_multi, O_overrun}, {m_code, m_pend, m_multi, m_ovr});
      end
    end
    nchk++;
    if (O_valid !== 1'b1 || O_code !== 2'd2 || O_multi !== 1'b0 || O_overrun !== 1'b0) begin
      nerr++;
      $display("FAIL b2b_reload: got valid=%b code=%0d multi=%b ovr=%b want 1/2/0/0", O_valid, O_code, O_multi, O_overrun);
    end
    tick();
    nchk++;
    if (O_valid !== 1'b0) begin
      nerr++;
      $display("FAIL b2b_drain: got valid=%b want 0", O_valid);
    end
    I = 4'b0000;
    repeat (15) tick();
  endtask

  task automatic test_reset_pending();
    int waited;
    O_ready = 1'b0;
    I = 4'b0001;
    waited = 0;
    while (O_valid !== 1'b1 && waited < 40) begin
      tick();
      waited++;
    end
    nchk++;
    if (O_valid !== 1'b1 || waited != LAT) begin
      nerr++;
      $display("FAIL rstp_setup: got valid=%b after %0d edges want valid=1 after %0d", O_valid, waited, LAT);
    end
    rst_n = 1'b0;
    #1;
    nchk++;
    if ({O_code, O_valid, O_multi, O_overrun} !== 5'b0) begin
      nerr++;
      $display("FAIL rstp_async: got code=%0d valid=%b multi=%b ovr=%b want all 0", O_code, O_valid, O_multi, O_overrun);
    end
    tick();
    rst_n = 1'b1;
    for (int n = 1; n <= LAT + 3; n++) begin
      tick();
      nchk++;
      if (O_valid !== (n >= LAT) || O_overrun !== 1'b0) begin
        nerr++;
        $display("FAIL rstp_repress_edge%0d: got valid=%b ovr=%b want valid=%b ovr=0", n, O_valid, O_overrun, (n >= LAT));
      end
    end
    nchk++;
    if (O_code !== 2'd0) begin
      nerr++;
      $display("FAIL rstp_code: got code=%0d want 0", O_code);
    end
    O_ready = 1'b1;
    I = 4'b0000;
    repeat (15) tick();
  endtask

  task automatic test_random();
    int hold;
    hold = 0;
    for (int n = 0; n < 2000; n++) begin
      if (hold == 0) begin
        I = 4'($urandom_range(0, 15));
        hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 14);
      end
      hold--;
      O_ready = ($urandom_range(0, 2) != 0);
      tick();
      nchk++;
      if ({O_code, O_valid, O_multi, O_overrun} !== {m_code, m_pend, m_multi, m_ovr}) begin
        nerr++;
        $display("FAIL random[%0d]: got code=%0d valid=%b multi=%b ovr=%b want code=%0d valid=%b multi=%b ovr=%b",
                 n, O_code, O_valid, O_multi, O_overrun, m_code, m_pend, m_multi, m_ovr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_glitch();
    test_multi_overrun();
    test_back_to_back();
    test_reset_pending();
    test_random();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
